// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default bit timing
// (the defaults are also used by the transmitter).
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

  localparam int UART_PERIOD_DEFAULT      = 868;
  localparam int UART_PERIOD_BITS_DEFAULT = 10;
  localparam int UART_DATA_BITS           = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RxD pin plus falling-edge detect.
// All flops reset to 1 so a line held low through reset never fakes a start edge.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rxd,
  output logic rx_s,
  output logic start_edge
);

  logic meta;
  logic rx_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      meta    <= rxd;
      rx_s    <= meta;
      rx_prev <= rx_s;
    end
  end

  assign start_edge = rx_prev & ~rx_s;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, LSB first: samples each bit at its midpoint and presents
// each byte with a one-cycle data_valid pulse (or framing_error pulse).
module uart_receiver
  import uart_pkg::*;
#(
  parameter int UART_PERIOD      = UART_PERIOD_DEFAULT,
  parameter int UART_PERIOD_BITS = UART_PERIOD_BITS_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rxd,
  output logic [UART_DATA_BITS-1:0] data_received,
  output logic                      data_valid,
  output logic                      framing_error,
  output logic                      busy
);

  localparam int CNT_W = $clog2(UART_DATA_BITS);
  localparam logic [UART_PERIOD_BITS-1:0] HALF_TICKS = UART_PERIOD_BITS'(UART_PERIOD / 2 - 1);
  localparam logic [UART_PERIOD_BITS-1:0] FULL_TICKS = UART_PERIOD_BITS'(UART_PERIOD - 1);
  localparam logic [CNT_W-1:0]            LAST_BIT   = CNT_W'(UART_DATA_BITS - 1);

  logic rx_s;
  logic start_edge;

  uart_rx_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .rxd        (rxd),
    .rx_s       (rx_s),
    .start_edge (start_edge)
  );

  uart_rx_state_t              state, state_next;
  logic [UART_PERIOD_BITS-1:0] timer, timer_next;
  logic [CNT_W-1:0]            bit_count, bit_count_next;
  logic [UART_DATA_BITS-1:0]   shift, shift_next;
  logic                        load_byte;
  logic                        stop_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      bit_count     <= '0;
      shift         <= '0;
      data_received <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_next;
      timer         <= timer_next;
      bit_count     <= bit_count_next;
      shift         <= shift_next;
      data_valid    <= load_byte;
      framing_error <= stop_bad;
      busy          <= (state_next != IDLE);
      if (load_byte) data_received <= shift;
    end
  end

  // Every sample point is reached when the down-counting timer hits zero.
  always_comb begin
    state_next     = state;
    timer_next     = timer;
    bit_count_next = bit_count;
    shift_next     = shift;
    load_byte      = 1'b0;
    stop_bad       = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          state_next = START;
          timer_next = HALF_TICKS;
        end
      end
      START: begin
        if (timer == '0) begin
          if (!rx_s) begin
            state_next     = DATA;
            timer_next     = FULL_TICKS;
            bit_count_next = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          timer_next = timer - 1'b1;
        end
      end
      DATA: begin
        if (timer == '0) begin
          shift_next     = {rx_s, shift[UART_DATA_BITS-1:1]};
          bit_count_next = bit_count + 1'b1;
          timer_next     = FULL_TICKS;
          if (bit_count == LAST_BIT) state_next = STOP;
        end else begin
          timer_next = timer - 1'b1;
        end
      end
      STOP: begin
        // Returning to IDLE at the stop midpoint leaves half a bit to catch
        // the next start edge.
        if (timer == '0) begin
          state_next = IDLE;
          if (rx_s) load_byte = 1'b1;
          else      stop_bad  = 1'b1;
        end else begin
          timer_next = timer - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at UART_PERIOD=16 with a behavioural
// serial transmitter and a frame-level expectation model.
module tb_uart_receiver;

  localparam int P   = 16;
  localparam int PB  = 5;
  // 2 synchroniser cycles to the detection cycle D, then D+153.
  localparam int LAT = 2 + P / 2 + 9 * P + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic [7:0] data_received;
  logic       data_valid;
  logic       framing_error;
  logic       busy;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  int         vq_cyc[$];
  logic [7:0] vq_data[$];
  int         fe_cyc[$];

  uart_receiver #(.UART_PERIOD(P), .UART_PERIOD_BITS(PB)) dut (
    .clk           (clk),
    .reset         (reset),
    .rxd           (rxd),
    .data_received (data_received),
    .data_valid    (data_valid),
    .framing_error (framing_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid) begin
      vq_cyc.push_back(cyc);
      vq_data.push_back(data_received);
    end
    if (framing_error) fe_cyc.push_back(cyc);
    if (data_valid || framing_error) begin
      compared++;
      if (data_valid && framing_error) begin
        mismatched++;
        $display("FAIL exclusive_pulses: both data_valid and framing_error high at cycle %0d", cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_queues();
    vq_cyc.delete();
    vq_data.delete();
    fe_cyc.delete();
  endtask

  // Behavioural 8N1 transmitter; c is the cycle the start bit went onto rxd.
  task automatic send_byte(input logic [7:0] b, input logic stop, output int c, output logic busy_mid);
    c   = cyc;
    rxd = 1'b0;
    tick(P / 2);
    busy_mid = busy;
    tick(P / 2);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(P);
    end
    rxd = stop;
    tick(P);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rxd   = 1'b1;
    tick(4);
    compared++;
    if (data_received !== 8'h00) begin mismatched++; $display("FAIL reset_data: got %h expected 00", data_received); end
    compared++;
    if (data_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b expected 0", data_valid); end
    compared++;
    if (framing_error !== 1'b0) begin mismatched++; $display("FAIL reset_ferr: got %b expected 0", framing_error); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b0;
    tick(4);
  endtask

  task automatic test_basic();
    int c;
    logic bm;
    clear_queues();
    send_byte(8'hA5, 1'b1, c, bm);
    tick(2 * P);
    compared++;
    if (vq_data.size() !== 1) begin
      mismatched++; $display("FAIL basic_count: got %0d pulses expected 1", vq_data.size());
    end else begin
      compared++;
      if (vq_data[0] !== 8'hA5) begin mismatched++; $display("FAIL basic_data: got %h expected a5", vq_data[0]); end
      compared++;
      if (vq_cyc[0] !== c + LAT) begin mismatched++; $display("FAIL basic_latency: got %0d expected %0d", vq_cyc[0], c + LAT); end
    end
    compared++;
    if (fe_cyc.size() !== 0) begin mismatched++; $display("FAIL basic_ferr: got %0d pulses expected 0", fe_cyc.size()); end
    compared++;
    if (bm !== 1'b1) begin mismatched++; $display("FAIL basic_busy_mid: got %b expected 1", bm); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_glitch();
    clear_queues();
    rxd = 1'b0;
    tick(3);
    rxd = 1'b1;
    tick(3 * P);
    compared++;
    if (vq_data.size() + fe_cyc.size() !== 0) begin
      mismatched++; $display("FAIL glitch_pulses: got %0d pulses expected 0", vq_data.size() + fe_cyc.size());
    end
    compared++;
    if (data_received !== 8'hA5) begin mismatched++; $display("FAIL glitch_data: got %h expected a5", data_received); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL glitch_busy: got %b expected 0", busy); end
  endtask

  task automatic test_framing();
    int c;
    logic bm;
    clear_queues();
    send_byte(8'h3C, 1'b0, c, bm);
    tick(20 * P);
    compared++;
    if (fe_cyc.size() !== 1) begin
      mismatched++; $display("FAIL framing_count: got %0d pulses expected 1", fe_cyc.size());
    end else begin
      compared++;
      if (fe_cyc[0] !== c + LAT) begin mismatched++; $display("FAIL framing_latency: got %0d expected %0d", fe_cyc[0], c + LAT); end
    end
    compared++;
    if (vq_data.size() !== 0) begin mismatched++; $display("FAIL framing_valid: got %0d pulses expected 0", vq_data.size()); end
    compared++;
    if (data_received !== 8'hA5) begin mismatched++; $display("FAIL framing_data_kept: got %h expected a5", data_received); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL framing_no_restart: busy %b expected 0", busy); end
    rxd = 1'b1;
    tick(2 * P);
    clear_queues();
    send_byte(8'h81, 1'b1, c, bm);
    tick(P);
    compared++;
    if (vq_data.size() !== 1 || fe_cyc.size() !== 0) begin
      mismatched++; $display("FAIL recover_count: got %0d valid %0d ferr expected 1 0", vq_data.size(), fe_cyc.size());
    end else begin
      compared++;
      if (vq_data[0] !== 8'h81) begin mismatched++; $display("FAIL recover_data: got %h expected 81", vq_data[0]); end
    end
  endtask

  task automatic test_back_to_back();
    int c0, c1;
    logic bm;
    clear_queues();
    send_byte(8'h00, 1'b1, c0, bm);
    send_byte(8'hFF, 1'b1, c1, bm);
    tick(P);
    compared++;
    if (vq_data.size() !== 2) begin
      mismatched++; $display("FAIL b2b_count: got %0d pulses expected 2", vq_data.size());
    end else begin
      compared++;
      if (vq_data[0] !== 8'h00 || vq_data[1] !== 8'hFF) begin
        mismatched++; $display("FAIL b2b_data: got %h %h expected 00 ff", vq_data[0], vq_data[1]);
      end
      compared++;
      if (vq_cyc[1] - vq_cyc[0] !== 10 * P) begin
        mismatched++; $display("FAIL b2b_spacing: got %0d expected %0d", vq_cyc[1] - vq_cyc[0], 10 * P);
      end
      compared++;
      if (vq_cyc[0] !== c0 + LAT) begin mismatched++; $display("FAIL b2b_latency: got %0d expected %0d", vq_cyc[0], c0 + LAT); end
    end
  endtask

  task automatic test_reset_midframe();
    int c;
    logic bm;
    clear_queues();
    rxd = 1'b0;
    tick(P);
    rxd = 1'b1;
    tick(4 * P + P / 2);
    reset = 1'b1;
    tick(2);
    compared++;
    if (data_received !== 8'h00 || data_valid !== 1'b0 || framing_error !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL midreset_outputs: got data %h valid %b ferr %b busy %b expected 00 0 0 0",
               data_received, data_valid, framing_error, busy);
    end
    reset = 1'b0;
    tick(P / 2 + 3 * P + P + 2 * P);
    compared++;
    if (vq_data.size() + fe_cyc.size() !== 0) begin
      mismatched++; $display("FAIL midreset_pulses: got %0d expected 0", vq_data.size() + fe_cyc.size());
    end
    send_byte(8'h5A, 1'b1, c, bm);
    tick(P);
    compared++;
    if (vq_data.size() !== 1) begin
      mismatched++; $display("FAIL midreset_next_count: got %0d expected 1", vq_data.size());
    end else begin
      compared++;
      if (vq_data[0] !== 8'h5A) begin mismatched++; $display("FAIL midreset_next_data: got %h expected 5a", vq_data[0]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_data[$];
    int         exp_cyc[$];
    int         exp_fe[$];
    int c;
    logic bm, good;
    logic [7:0] b;
    clear_queues();
    for (int n = 0; n < 24; n++) begin
      b    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 5) != 0);
      send_byte(b, good, c, bm);
      if (good) begin
        exp_data.push_back(b);
        exp_cyc.push_back(c + LAT);
      end else begin
        exp_fe.push_back(c + LAT);
        rxd = 1'b1;
        tick(P);
      end
      tick($urandom_range(0, 40));
    end
    tick(P);
    compared++;
    if (vq_data.size() !== exp_data.size() || fe_cyc.size() !== exp_fe.size()) begin
      mismatched++;
      $display("FAIL random_counts: got %0d valid %0d ferr expected %0d %0d",
               vq_data.size(), fe_cyc.size(), exp_data.size(), exp_fe.size());
    end else begin
      for (int i = 0; i < exp_data.size(); i++) begin
        compared++;
        if (vq_data[i] !== exp_data[i] || vq_cyc[i] !== exp_cyc[i]) begin
          mismatched++;
          $display("FAIL random_byte%0d: got %h at %0d expected %h at %0d", i, vq_data[i], vq_cyc[i], exp_data[i], exp_cyc[i]);
        end
      end
      for (int i = 0; i < exp_fe.size(); i++) begin
        compared++;
        if (fe_cyc[i] !== exp_fe[i]) begin
          mismatched++; $display("FAIL random_ferr%0d: got %0d expected %0d", i, fe_cyc[i], exp_fe[i]);
        end
      end
    end
  endtask

  task automatic test_loopback();
    int cs[256];
    int c;
    logic bm;
    clear_queues();
    for (int n = 0; n < 256; n++) begin
      send_byte(8'(n), 1'b1, c, bm);
      cs[n] = c;
    end
    tick(P);
    compared++;
    if (vq_data.size() !== 256 || fe_cyc.size() !== 0) begin
      mismatched++; $display("FAIL loop_counts: got %0d valid %0d ferr expected 256 0", vq_data.size(), fe_cyc.size());
    end else begin
      for (int n = 0; n < 256; n++) begin
        compared++;
        if (vq_data[n] !== 8'(n) || vq_cyc[n] !== cs[n] + LAT) begin
          mismatched++;
          $display("FAIL loop_byte%0d: got %h at %0d expected %h at %0d", n, vq_data[n], vq_cyc[n], 8'(n), cs[n] + LAT);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    rxd   = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
